// File: rtl/dcm_reset_sequencer.sv
// Power-up reset sequencer for a two-stage DCM chain (50 -> 180 -> 108 MHz).
// Brings up the first DCM, then the second, waits for both locks to be
// continuously stable, and only then releases the downstream system reset.
// Lock loss or lock timeout triggers a full restart. When the retry budget
// is used up, the block parks in a sticky FAULT state until reset.
// The current FSM state is exported on state_dbg for observation.
module dcm_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 8
) (
  input  logic       CLK_50MHz,
  input  logic       reset,
  input  logic       locked0,
  input  logic       locked1,
  output logic       dcm0_rst,
  output logic       dcm1_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [2:0] state_dbg
);

  // One counter serves both the reset-hold phases and the stability window.
  localparam int unsigned CNT_MAX = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RST0   = 3'd0,
    ST_WAIT0  = 3'd1,
    ST_RST1   = 3'd2,
    ST_WAIT1  = 3'd3,
    ST_STABLE = 3'd4,
    ST_RUN    = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0] retry_count_q, retry_count_d;
  logic       dcm0_rst_q, dcm0_rst_d;
  logic       dcm1_rst_q, dcm1_rst_d;
  logic       sys_reset_q, sys_reset_d;
  logic       ready_q, ready_d;
  logic       fault_q, fault_d;
  logic       do_retry;

  logic       lk0_meta_q, lk0_meta_d;
  logic       lk0_s_q, lk0_s_d;
  logic       lk1_meta_q, lk1_meta_d;
  logic       lk1_s_q, lk1_s_d;

  // Two-flop synchronizer inputs for the asynchronous LOCKED signals.
  always_comb begin
    lk0_meta_d = locked0;
    lk0_s_d    = lk0_meta_q;
    lk1_meta_d = locked1;
    lk1_s_d    = lk1_meta_q;
  end

  // Synchronizer flops; cleared by reset so stale locks are never trusted.
  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      lk0_meta_q <= 1'b0;
      lk0_s_q    <= 1'b0;
      lk1_meta_q <= 1'b0;
      lk1_s_q    <= 1'b0;
    end else begin
      lk0_meta_q <= lk0_meta_d;
      lk0_s_q    <= lk0_s_d;
      lk1_meta_q <= lk1_meta_d;
      lk1_s_q    <= lk1_s_d;
    end
  end

  // Next-state, counters, retry bookkeeping and registered output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    retry_count_d = retry_count_q;
    do_retry      = 1'b0;

    case (state_q)
      ST_RST0: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RST_LAST) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        tmo_d = tmo_q + 1'b1;
        if (lk0_s_q)                state_d  = ST_RST1;
        else if (tmo_q == TMO_LAST) do_retry = 1'b1;
      end
      ST_RST1: begin
        cnt_d = cnt_q + 1'b1;
        if (!lk0_s_q)               do_retry = 1'b1;
        else if (cnt_q == RST_LAST) state_d  = ST_WAIT1;
      end
      ST_WAIT1: begin
        tmo_d = tmo_q + 1'b1;
        // Lock loss and timeout collapse into the same single retry.
        if (!lk0_s_q)               do_retry = 1'b1;
        else if (lk1_s_q)           state_d  = ST_STABLE;
        else if (tmo_q == TMO_LAST) do_retry = 1'b1;
      end
      ST_STABLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!lk0_s_q || !lk1_s_q)      do_retry = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (!lk0_s_q || !lk1_s_q) do_retry = 1'b1;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    if (do_retry) begin
      if ((32'(retry_count_q) + 32'd1) >= MAX_RETRIES) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_RST0;
        if (retry_count_q != 4'hF) retry_count_d = retry_count_q + 4'd1;
      end
    end

    // Every phase starts its own timing window from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
      tmo_d = '0;
    end

    // Outputs follow the state being entered so they change on the same edge.
    dcm0_rst_d  = (state_d == ST_RST0) || (state_d == ST_FAULT);
    dcm1_rst_d  = (state_d == ST_RST0) || (state_d == ST_WAIT0) ||
                  (state_d == ST_RST1) || (state_d == ST_FAULT);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  // State, counters and registered outputs; reset restarts the sequence.
  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      state_q       <= ST_RST0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      retry_count_q <= 4'd0;
      dcm0_rst_q    <= 1'b1;
      dcm1_rst_q    <= 1'b1;
      sys_reset_q   <= 1'b1;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      retry_count_q <= retry_count_d;
      dcm0_rst_q    <= dcm0_rst_d;
      dcm1_rst_q    <= dcm1_rst_d;
      sys_reset_q   <= sys_reset_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  assign dcm0_rst    = dcm0_rst_q;
  assign dcm1_rst    = dcm1_rst_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Directed bench for dcm_reset_sequencer with short timing parameters.
// Time t counts rising edges since the reset edge; all sampling and driving
// happens 1 ns after a rising edge.
module tb_dcm_reset_sequencer;

  localparam logic [2:0] S_RST0   = 3'd0;
  localparam logic [2:0] S_WAIT0  = 3'd1;
  localparam logic [2:0] S_RST1   = 3'd2;
  localparam logic [2:0] S_WAIT1  = 3'd3;
  localparam logic [2:0] S_STABLE = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic       clk;
  logic       reset;
  logic       locked0;
  logic       locked1;
  logic       dcm0_rst;
  logic       dcm1_rst;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [2:0] state_dbg;

  int vectors;
  int miscompares;

  dcm_reset_sequencer #(
    .RST_CYCLES   (3),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(4),
    .MAX_RETRIES  (2)
  ) dut (
    .CLK_50MHz  (clk),
    .reset      (reset),
    .locked0    (locked0),
    .locked1    (locked1),
    .dcm0_rst   (dcm0_rst),
    .dcm1_rst   (dcm1_rst),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .state_dbg  (state_dbg)
  );

  // Clock and global watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves t=0: the reset edge has just loaded RST0.
  task automatic do_reset();
    reset   = 1'b1;
    locked0 = 1'b0;
    locked1 = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  // From t=0 with both locks low; locked0 rises at t=5; ends at t=11 (WAIT1 entry).
  task automatic seq_to_wait1();
    tick(2);
    vectors++;
    if (state_dbg !== S_RST0 || dcm0_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL rst0_hold: state=%0d dcm0_rst=%b, want state=%0d dcm0_rst=1", state_dbg, dcm0_rst, S_RST0);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_WAIT0 || {dcm0_rst, dcm1_rst, sys_reset, ready} !== 4'b0110) begin
      miscompares++;
      $display("FAIL wait0_entry: state=%0d outs=%b, want state=%0d outs=0110", state_dbg,
               {dcm0_rst, dcm1_rst, sys_reset, ready}, S_WAIT0);
    end
    tick(2);
    locked0 = 1'b1;
    tick(2);
    vectors++;
    if (state_dbg !== S_WAIT0) begin
      miscompares++;
      $display("FAIL sync_latency0: state=%0d, want %0d", state_dbg, S_WAIT0);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_RST1 || {dcm0_rst, dcm1_rst} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst1_entry: state=%0d dcm=%b, want state=%0d dcm=01", state_dbg, {dcm0_rst, dcm1_rst}, S_RST1);
    end
    tick(2);
    vectors++;
    if (dcm1_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL rst1_hold: dcm1_rst=%b, want 1", dcm1_rst);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_WAIT1 || dcm1_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL wait1_entry: state=%0d dcm1_rst=%b, want state=%0d dcm1_rst=0", state_dbg, dcm1_rst, S_WAIT1);
    end
  endtask

  // Continues to t=18: locked1 rises at t=15, STABLE entered at t=18.
  task automatic seq_to_stable();
    seq_to_wait1();
    tick(4);
    locked1 = 1'b1;
    tick(3);
    vectors++;
    if (state_dbg !== S_STABLE || sys_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL stable_entry: state=%0d sys_reset=%b, want state=%0d sys_reset=1", state_dbg, sys_reset, S_STABLE);
    end
  endtask

  // Continues to t=22: RUN exactly 4 cycles after STABLE entry.
  task automatic seq_to_run(input logic [3:0] exp_retry);
    seq_to_stable();
    tick(3);
    vectors++;
    if (ready !== 1'b0 || sys_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL stable_last: ready=%b sys_reset=%b, want ready=0 sys_reset=1", ready, sys_reset);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_RUN || {dcm0_rst, dcm1_rst, sys_reset, ready, fault} !== 5'b00010
        || retry_count !== exp_retry) begin
      miscompares++;
      $display("FAIL run_entry: state=%0d outs=%b retry=%0d, want state=%0d outs=00010 retry=%0d", state_dbg,
               {dcm0_rst, dcm1_rst, sys_reset, ready, fault}, retry_count, S_RUN, exp_retry);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset   = 1'b1;
    locked0 = 1'b1;
    locked1 = 1'b1;
    tick(5);
    vectors++;
    if (state_dbg !== S_RST0 || {dcm0_rst, dcm1_rst, sys_reset, ready, fault} !== 5'b11100
        || retry_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d outs=%b retry=%0d, want state=0 outs=11100 retry=0", state_dbg,
               {dcm0_rst, dcm1_rst, sys_reset, ready, fault}, retry_count);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    seq_to_run(4'd0);
  endtask

  // Starts in RUN at t=22 with both locks high.
  task automatic test_lock_loss();
    bit reached;
    locked1 = 1'b0;
    tick(2);
    vectors++;
    if (state_dbg !== S_RUN || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL loss_sync_delay: state=%0d ready=%b, want state=%0d ready=1", state_dbg, ready, S_RUN);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_RST0 || {sys_reset, ready} !== 2'b10 || retry_count !== 4'd1) begin
      miscompares++;
      $display("FAIL loss_retry: state=%0d sys_reset=%b ready=%b retry=%0d, want state=0 sys_reset=1 ready=0 retry=1",
               state_dbg, sys_reset, ready, retry_count);
    end
    locked1 = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      tick(1);
      if (ready === 1'b1) reached = 1'b1;
    end
    vectors++;
    if (!reached || state_dbg !== S_RUN || retry_count !== 4'd1 || sys_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_recover: reached=%b state=%0d retry=%0d sys_reset=%b, want reached=1 state=%0d retry=1 sys_reset=0",
               reached, state_dbg, retry_count, sys_reset, S_RUN);
    end
  endtask

  task automatic test_stability();
    do_reset();
    seq_to_stable();
    locked0 = 1'b0;
    tick(2);
    locked0 = 1'b1;
    vectors++;
    if (state_dbg !== S_STABLE) begin
      miscompares++;
      $display("FAIL stab_still: state=%0d, want %0d", state_dbg, S_STABLE);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_RST0 || ready !== 1'b0 || retry_count !== 4'd1) begin
      miscompares++;
      $display("FAIL stab_retry: state=%0d ready=%b retry=%0d, want state=0 ready=0 retry=1", state_dbg, ready, retry_count);
    end
    tick(1);
    vectors++;
    if (state_dbg === S_RUN || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stab_no_run: state=%0d ready=%b, want state!=%0d ready=0", state_dbg, ready, S_RUN);
    end
  endtask

  // lk0_s first reads 0 at the edge where the WAIT1 timeout expires (t=31).
  task automatic test_simultaneous();
    do_reset();
    seq_to_wait1();
    tick(17);
    locked0 = 1'b0;
    tick(2);
    vectors++;
    if (state_dbg !== S_WAIT1 || retry_count !== 4'd0) begin
      miscompares++;
      $display("FAIL sim_before: state=%0d retry=%0d, want state=%0d retry=0", state_dbg, retry_count, S_WAIT1);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_RST0 || retry_count !== 4'd1) begin
      miscompares++;
      $display("FAIL sim_retry: state=%0d retry=%0d, want state=0 retry=1", state_dbg, retry_count);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_RST0 || retry_count !== 4'd1) begin
      miscompares++;
      $display("FAIL sim_single: state=%0d retry=%0d, want state=0 retry=1", state_dbg, retry_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(22);
    vectors++;
    if (state_dbg !== S_WAIT0 || retry_count !== 4'd0) begin
      miscompares++;
      $display("FAIL tmo_wait0_last: state=%0d retry=%0d, want state=%0d retry=0", state_dbg, retry_count, S_WAIT0);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_RST0 || retry_count !== 4'd1 || dcm0_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_first: state=%0d retry=%0d dcm0_rst=%b, want state=0 retry=1 dcm0_rst=1", state_dbg,
               retry_count, dcm0_rst);
    end
    tick(22);
    vectors++;
    if (state_dbg !== S_WAIT0) begin
      miscompares++;
      $display("FAIL tmo_wait0_again: state=%0d, want %0d", state_dbg, S_WAIT0);
    end
    tick(1);
    vectors++;
    if (state_dbg !== S_FAULT || {dcm0_rst, dcm1_rst, sys_reset, ready, fault} !== 5'b11101
        || retry_count !== 4'd1) begin
      miscompares++;
      $display("FAIL tmo_fault: state=%0d outs=%b retry=%0d, want state=%0d outs=11101 retry=1", state_dbg,
               {dcm0_rst, dcm1_rst, sys_reset, ready, fault}, retry_count, S_FAULT);
    end
    locked0 = 1'b1;
    locked1 = 1'b1;
    tick(8);
    vectors++;
    if (state_dbg !== S_FAULT || fault !== 1'b1 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_sticky: state=%0d fault=%b ready=%b, want state=%0d fault=1 ready=0", state_dbg, fault,
               ready, S_FAULT);
    end
  endtask

  // Starts in FAULT; a single reset cycle must clear everything on that edge.
  task automatic test_reset_recovery();
    do_reset();
    vectors++;
    if (state_dbg !== S_RST0 || fault !== 1'b0 || retry_count !== 4'd0 || {dcm0_rst, dcm1_rst} !== 2'b11) begin
      miscompares++;
      $display("FAIL recover_reset: state=%0d fault=%b retry=%0d dcm=%b, want state=0 fault=0 retry=0 dcm=11",
               state_dbg, fault, retry_count, {dcm0_rst, dcm1_rst});
    end
    seq_to_run(4'd0);
  endtask

  // Test sequence and final report
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    locked0     = 1'b0;
    locked1     = 1'b0;
    test_reset();
    test_nominal();
    test_lock_loss();
    test_stability();
    test_simultaneous();
    test_timeout();
    test_reset_recovery();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcm_reset_sequencer.md
DCM_RESET_SEQUENCER -- requirements
Module: dcm_reset_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of cycles each DCM reset is held asserted.
REQ-002 Parameter LOCK_TIMEOUT, default 50000: cycles to wait for a lock before a retry (1 ms at 50 MHz).
REQ-003 Parameter STABLE_CYCLES, default 1024: cycles both locks must stay high before release.
REQ-004 Parameter MAX_RETRIES, default 8: retry count at which the block enters FAULT.
REQ-005 Port CLK_50MHz, input, 1 bit: sole clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port locked0, input, 1 bit: asynchronous LOCKED from the first-stage DCM (50 to 180 MHz).
REQ-008 Port locked1, input, 1 bit: asynchronous LOCKED from the second-stage DCM (180 to 108 MHz).
REQ-009 Port dcm0_rst, output, 1 bit: RST to the first-stage DCM.
REQ-010 Port dcm1_rst, output, 1 bit: RST to the second-stage DCM.
REQ-011 Port sys_reset, output, 1 bit: active-high reset for downstream pixel-clock logic.
REQ-012 Port ready, output, 1 bit: both clocks locked and stable.
REQ-013 Port fault, output, 1 bit: sticky; retries exhausted.
REQ-014 Port retry_count, output, 4 bits: saturating count of retries since reset.

Function
REQ-015 locked0 and locked1 SHALL each pass through a 2-flop synchronizer (lk0_s, lk1_s); all decisions SHALL use only the synchronized values.
REQ-016 The FSM SHALL have the states RST0, WAIT0, RST1, WAIT1, STABLE, RUN and FAULT; all outputs are registered and update on the same edge as the state.
REQ-017 RST0 behaviour:
  - dcm0_rst=1, dcm1_rst=1.
  - Held for exactly RST_CYCLES cycles, then go to WAIT0.
REQ-018 WAIT0 behaviour:
  - dcm0_rst=0, dcm1_rst=1.
  - lk0_s=1: go to RST1.
  - Timeout counter reaches LOCK_TIMEOUT: retry.
REQ-019 RST1 behaviour:
  - dcm1_rst=1, held for RST_CYCLES cycles, then go to WAIT1.
  - lk0_s=0 at any time: retry.
REQ-020 WAIT1 behaviour:
  - dcm1_rst=0.
  - lk1_s=1: go to STABLE.
  - lk0_s=0 or timeout: retry.
REQ-021 STABLE behaviour:
  - Counts while lk0_s and lk1_s are both 1.
  - After STABLE_CYCLES consecutive cycles: go to RUN.
  - Either lock low: retry.
REQ-022 RUN behaviour: sys_reset=0, ready=1; either lock low: retry.
REQ-023 sys_reset SHALL be 1 and ready SHALL be 0 in every state except RUN.
REQ-024 Retry action:
  - If retry_count+1 >= MAX_RETRIES: go to FAULT.
  - Otherwise: go to RST0 and increment retry_count.
  - retry_count saturates at 15.
REQ-025 FAULT SHALL set dcm0_rst=1, dcm1_rst=1, sys_reset=1, fault=1, and is left only via reset.
REQ-026 The timeout counter and the stable/reset counter SHALL clear on every state change.
REQ-027 A lock loss and a timeout expiring in the same cycle SHALL cause a single retry with a single increment.
REQ-028 In RUN, a lock glitch of at least 1 synchronized cycle SHALL force sys_reset=1 on the next edge.

Reset
REQ-029 On reset=1 at an edge, the block SHALL enter RST0 with:
  - dcm0_rst=1, dcm1_rst=1, sys_reset=1, ready=0, fault=0;
  - retry_count=0, counters=0, synchronizers=0.
REQ-030 Reset asserted mid-sequence, including in RUN or FAULT, SHALL take effect on that edge and restart the sequence from RST0.

Verification (bench parameters: RST_CYCLES=3, LOCK_TIMEOUT=20, STABLE_CYCLES=4, MAX_RETRIES=2)
REQ-031 Nominal:
  - Stimulus: release reset; raise locked0 5 cycles later; raise locked1 10 cycles after that.
  - Response: dcm0_rst falls after 3 cycles; dcm1_rst falls 3 cycles after RST1 entry; ready=1 and sys_reset=0 exactly 4 cycles after STABLE entry; retry_count=0.
REQ-032 Timeout:
  - Stimulus: locked0 held at 0.
  - Response: 20 cycles in WAIT0, then RST0 again with retry_count=1; a second timeout gives FAULT with fault=1 and both DCM resets at 1.
REQ-033 Loss of lock in RUN:
  - Stimulus: drop locked1 for 3 cycles.
  - Response: sys_reset=1 and ready=0 within 3 cycles (2 sync + 1); RST0 re-entered; retry_count=1; full sequence completes again.
REQ-034 Stability filter:
  - Stimulus: in STABLE, drop locked0 for 2 cycles after 3 stable cycles.
  - Response: RUN is never reached; retry to RST0.
REQ-035 Reset recovery:
  - Stimulus: assert reset for 1 cycle while in FAULT.
  - Response: fault=0, retry_count=0, state RST0 on that edge; nominal sequence then succeeds.
REQ-036 Simultaneous events:
  - Stimulus: lk0_s falls on the same cycle the WAIT1 timeout expires.
  - Response: retry_count increments by exactly 1.
